// File: rtl/debug_ctrl_pkg.sv
// debug_ctrl_pkg
//   Shared definitions for the pipeline debug sequencer: command opcodes,
//   sequencer state encoding and the number of command bytes per
//   instruction word.
//   No ports (package).

package debug_ctrl_pkg;

  localparam int BYTES_PER_WORD = 4;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_STEP = 8'h03;
  localparam logic [7:0] CMD_PRST = 8'h04;
  localparam logic [7:0] CMD_STOP = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_CNT  = 3'd1,
    ST_LOAD_DATA = 3'd2,
    ST_RUN       = 3'd3,
    ST_STEP      = 3'd4,
    ST_PRST      = 3'd5
  } state_t;

  // States in which the command stream is allowed to deliver a byte.
  function automatic logic accepts_bytes(state_t s);
    return (s == ST_IDLE) || (s == ST_LOAD_CNT) ||
           (s == ST_LOAD_DATA) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/debug_word_assembler.sv
// debug_word_assembler
//   Collects command bytes MSB-first into instruction words. When the last
//   byte of a word is accepted, word_complete is high in that same cycle and
//   on the following cycle word_valid pulses with the assembled word.
// Ports
//   clk           in   1         clock
//   rst_n         in   1         synchronous, active-low reset
//   clear         in   1         restart byte position at the first byte
//   byte_valid    in   1         byte_data is consumed this cycle
//   byte_data     in   NB_BYTE   payload byte
//   word_complete out  1         combinational: this byte completes a word
//   word_valid    out  1         registered one-cycle word strobe
//   word          out  NB_WORD   registered assembled word
// NB_WORD must equal NB_BYTE * BYTES_PER_WORD.

module debug_word_assembler
  import debug_ctrl_pkg::*;
#(
  parameter int NB_BYTE = 8,
  parameter int NB_WORD = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               byte_valid,
  input  logic [NB_BYTE-1:0] byte_data,
  output logic               word_complete,
  output logic               word_valid,
  output logic [NB_WORD-1:0] word
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0]   byte_cnt_reg;
  // lane_reg[0] holds the most recent byte; older bytes move to higher lanes.
  logic [NB_BYTE-1:0] lane_reg [BYTES_PER_WORD-1];
  logic [NB_WORD-1:0] word_next;

  assign word_complete = byte_valid && (byte_cnt_reg == LAST_BYTE);

  // The byte arriving now is the least significant one of the word.
  assign word_next[NB_BYTE-1:0] = byte_data;
  generate
    for (genvar gi = 1; gi < BYTES_PER_WORD; gi++) begin : g_word
      assign word_next[gi*NB_BYTE +: NB_BYTE] = lane_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt_reg <= '0;
      word_valid   <= 1'b0;
      word         <= '0;
      for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
        lane_reg[i] <= '0;
      end
    end else begin
      word_valid <= word_complete;
      if (word_complete) begin
        word <= word_next;
      end
      if (clear) begin
        byte_cnt_reg <= '0;
      end else if (byte_valid) begin
        byte_cnt_reg <= word_complete ? '0 : byte_cnt_reg + CNT_W'(1);
        lane_reg[0]  <= byte_data;
        for (int i = BYTES_PER_WORD - 2; i > 0; i--) begin
          lane_reg[i] <= lane_reg[i-1];
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// pipeline_debug_ctrl
//   Sequencer between the host byte link and the MIPS pipeline. Decodes a
//   valid/ready byte command stream: LOAD (program instruction memory, then
//   reset the pipeline), RUN (advance until HALT or STOP), STEP (advance one
//   cycle), PRST (one-cycle pipeline reset) and STOP. All outputs registered.
// Optional feature macro: PIPELINE_DEBUG_CYCLE_CNT_EN builds a saturating
//   counter of advanced cycles; without it o_cycle_count is tied to 0.
// Ports
//   i_clock       in   1                   clock
//   i_reset       in   1                   synchronous, active-low reset
//   i_cmd_data    in   NB_CMD              command/payload byte
//   i_cmd_valid   in   1                   byte valid
//   o_cmd_ready   out  1                   byte accepted on valid&ready
//   i_halt        in   1                   pipeline retired HALT (level)
//   o_pipe_valid  out  1                   pipeline advance enable
//   o_pipe_reset  out  1                   one-cycle pipeline reset pulse
//   o_imem_we     out  1                   imem write strobe
//   o_imem_addr   out  LOG2_N_INSMEM_ADDR  imem write word address
//   o_imem_data   out  NB_INSTR            imem write data
//   o_done        out  1                   pulse: run/step ended on HALT
//   o_err         out  1                   pulse: unknown/illegal command
//   o_busy        out  1                   sequencer not idle
//   o_cycle_count out  NB_CYCLE_CNT        advanced cycle count

module pipeline_debug_ctrl #(
  parameter int NB_INSTR           = 32,
  parameter int N_ADDR             = 32,
  parameter int LOG2_N_INSMEM_ADDR = 5,
  parameter int NB_CMD             = 8,
  parameter int NB_CYCLE_CNT       = 32
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NB_CMD-1:0]             i_cmd_data,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic                          i_halt,
  output logic                          o_pipe_valid,
  output logic                          o_pipe_reset,
  output logic                          o_imem_we,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_imem_addr,
  output logic [NB_INSTR-1:0]           o_imem_data,
  output logic                          o_done,
  output logic                          o_err,
  output logic                          o_busy,
  output logic [NB_CYCLE_CNT-1:0]       o_cycle_count
);

  import debug_ctrl_pkg::*;

  localparam logic [LOG2_N_INSMEM_ADDR-1:0] LAST_ADDR = LOG2_N_INSMEM_ADDR'(N_ADDR - 1);

  state_t state_reg, state_next;

  // Program length in words and words written so far; the write address
  // wraps separately so depths that are not a power of two still work.
  logic [NB_CMD-1:0]             word_total_reg, word_total_next;
  logic [NB_CMD-1:0]             word_idx_reg, word_idx_next;
  logic [LOG2_N_INSMEM_ADDR-1:0] wr_addr_reg, wr_addr_next;
  logic [NB_CMD-1:0]             word_idx_inc;

  logic done_next;
  logic err_next;
  logic accept;
  logic asm_clear;
  logic asm_byte_valid;
  logic asm_word_complete;

  assign accept         = i_cmd_valid && o_cmd_ready;
  assign word_idx_inc   = word_idx_reg + NB_CMD'(1);
  assign asm_byte_valid = accept && (state_reg == ST_LOAD_DATA);
  assign asm_clear      = accept && (state_reg == ST_LOAD_CNT);

  debug_word_assembler #(
    .NB_BYTE (NB_CMD),
    .NB_WORD (NB_INSTR)
  ) u_word_assembler (
    .clk           (i_clock),
    .rst_n         (i_reset),
    .clear         (asm_clear),
    .byte_valid    (asm_byte_valid),
    .byte_data     (i_cmd_data),
    .word_complete (asm_word_complete),
    .word_valid    (o_imem_we),
    .word          (o_imem_data)
  );

  always_comb begin
    state_next      = state_reg;
    word_total_next = word_total_reg;
    word_idx_next   = word_idx_reg;
    wr_addr_next    = wr_addr_reg;
    done_next       = 1'b0;
    err_next        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (i_cmd_data)
            CMD_LOAD: state_next = ST_LOAD_CNT;
            CMD_RUN:  state_next = ST_RUN;
            CMD_STEP: state_next = ST_STEP;
            CMD_PRST: state_next = ST_PRST;
            CMD_STOP: state_next = ST_IDLE;
            default:  err_next   = 1'b1;
          endcase
        end
      end

      ST_LOAD_CNT: begin
        if (accept) begin
          if (i_cmd_data == '0) begin
            // Empty program: still reset the pipeline.
            state_next = ST_PRST;
          end else begin
            word_total_next = i_cmd_data;
            word_idx_next   = '0;
            wr_addr_next    = '0;
            state_next      = ST_LOAD_DATA;
          end
        end
      end

      ST_LOAD_DATA: begin
        if (asm_word_complete) begin
          word_idx_next = word_idx_inc;
          wr_addr_next  = (wr_addr_reg == LAST_ADDR) ? '0
                          : wr_addr_reg + LOG2_N_INSMEM_ADDR'(1);
          if (word_idx_inc == word_total_reg) begin
            state_next = ST_PRST;
          end
        end
      end

      ST_RUN: begin
        // Any byte other than STOP is still consumed but flagged.
        if (accept && (i_cmd_data != CMD_STOP)) begin
          err_next = 1'b1;
        end
        // HALT has priority over a simultaneous STOP.
        if (i_halt) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else if (accept && (i_cmd_data == CMD_STOP)) begin
          state_next = ST_IDLE;
        end
      end

      ST_STEP: begin
        done_next  = i_halt;
        state_next = ST_IDLE;
      end

      ST_PRST: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_reg      <= ST_IDLE;
      word_total_reg <= '0;
      word_idx_reg   <= '0;
      wr_addr_reg    <= '0;
      o_cmd_ready    <= 1'b0;
      o_pipe_valid   <= 1'b0;
      o_pipe_reset   <= 1'b0;
      o_imem_addr    <= '0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      word_total_reg <= word_total_next;
      word_idx_reg   <= word_idx_next;
      wr_addr_reg    <= wr_addr_next;
      o_cmd_ready    <= accepts_bytes(state_next);
      o_pipe_valid   <= (state_next == ST_RUN) || (state_next == ST_STEP);
      o_pipe_reset   <= (state_next == ST_PRST);
      o_done         <= done_next;
      o_err          <= err_next;
      o_busy         <= (state_next != ST_IDLE);
      if (asm_word_complete) begin
        o_imem_addr <= wr_addr_reg;
      end
    end
  end

`ifdef PIPELINE_DEBUG_CYCLE_CNT_EN
  logic [NB_CYCLE_CNT-1:0] cycle_cnt_reg;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      cycle_cnt_reg <= '0;
    end else if (o_pipe_reset) begin
      cycle_cnt_reg <= '0;
    end else if (o_pipe_valid && (cycle_cnt_reg != '1)) begin
      cycle_cnt_reg <= cycle_cnt_reg + NB_CYCLE_CNT'(1);
    end
  end

  assign o_cycle_count = cycle_cnt_reg;
`else
  assign o_cycle_count = '0;
`endif

endmodule
